// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller wrapped around a combinational 16-bit ALU.
// Holds an 8 x 16 register file and runs one instruction per IDLE->EXEC->WB pass.
module alu_issue_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [3:0]  instr_op,
   input  logic [2:0]  instr_rd,
   input  logic [2:0]  instr_rs1,
   input  logic [2:0]  instr_rs2,
   input  logic [15:0] instr_imm,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_sel,
   input  logic [15:0] alu_result,
   input  logic        alu_carry,
   input  logic        alu_zero,
   input  logic        alu_negative,
   input  logic        alu_overflow,
   output logic        wb_valid,
   output logic [2:0]  wb_rd,
   output logic [15:0] wb_data,
   output logic [3:0]  flags_q
);

   localparam logic [3:0] OP_LDI = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [3:0]  op_reg;
   logic [2:0]  rd_reg;
   logic [15:0] imm_reg;
   logic [3:0]  flags_hold_reg;
   logic [15:0] rf [8];
   logic        accept;
   logic        is_ldi;

   assign accept = instr_valid && instr_ready;
   assign is_ldi = (op_reg == OP_LDI);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // wb_valid decodes straight from the state register so it drops as soon as reset asserts
   always_comb begin
      state_next  = state_reg;
      instr_ready = 1'b0;
      wb_valid    = 1'b0;
      case (state_reg)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_next = EXEC;
         end
         EXEC: state_next = WB;
         WB: begin
            wb_valid   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Sources are read here, before this instruction's own write-back can alias them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_reg  <= '0;
         rd_reg  <= '0;
         imm_reg <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
      end else if (accept) begin
         op_reg <= instr_op;
         rd_reg <= instr_rd;
         alu_a  <= rf[instr_rs1];
         alu_b  <= rf[instr_rs2];
         if (instr_op == OP_LDI) imm_reg <= instr_imm;
         else                    alu_sel <= instr_op;
      end
   end

   // wb_data doubles as the result hold register and keeps its value after WB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_rd          <= '0;
         wb_data        <= '0;
         flags_hold_reg <= '0;
      end else if (state_reg == EXEC) begin
         wb_rd <= rd_reg;
         if (is_ldi) begin
            wb_data <= imm_reg;
         end else begin
            wb_data        <= alu_result;
            flags_hold_reg <= {alu_carry, alu_zero, alu_negative, alu_overflow};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else if (state_reg == WB && !is_ldi) begin
         flags_q <= flags_hold_reg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else if (state_reg == WB) begin
         rf[rd_reg] <= wb_data;
      end
   end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential issue/write-back controller that sits directly upstream of the team's combinational 16-bit ALU. It holds an 8-entry × 16-bit register file and accepts one instruction at a time over a valid/ready handshake. For each instruction it registers the operands and select code onto the ALU inputs, captures the ALU result and flags, then writes the result back to the destination register and the flags register. It is the minimal execution core around the ALU: register-to-register ops plus load-immediate.

## Interface
Parameters:
- none; widths are fixed (16-bit data, 8 registers, 4-bit op).

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous and active-low
- instr_valid  in  1  instruction present
- instr_ready  out  1  block can accept; high only in IDLE
- instr_op  in  4  0 ADD, 1 SUB, 2 AND, 3 XOR, 4 OR, 5 NOT(rs1), 6–14 unused, 15 LDI
- instr_rd  in  3  destination register index
- instr_rs1  in  3  source A register index
- instr_rs2  in  3  source B register index
- instr_imm  in  16  immediate, used by LDI only
- alu_a  out  16  registered ALU operand A
- alu_b  out  16  registered ALU operand B
- alu_sel  out  4  registered ALU select (= instr_op for ops 0–14)
- alu_result  in  16  ALU result, combinational from alu_a/alu_b/alu_sel
- alu_carry, alu_zero, alu_negative, alu_overflow  in  1 each  ALU flags
- wb_valid  out  1  one-cycle pulse in WB
- wb_rd  out  3  register being written during WB
- wb_data  out  16  value being written during WB
- flags_q  out  4  {carry, zero, negative, overflow} from the last ALU op

## Operation
- FSM states: IDLE → EXEC → WB → IDLE.
- No other transitions, except that reset forces IDLE from any state.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at an edge:
    - latch op and rd;
    - load alu_a←rf[rs1], alu_b←rf[rs2], alu_sel←op;
    - for LDI, latch imm and leave alu_sel unchanged;
    - go to EXEC.
- EXEC:
  - instr_ready=0.
  - At the edge, capture alu_result and the four flags into internal hold registers; for LDI, capture imm instead and no flags.
  - Go to WB.
- WB:
  - wb_valid=1; wb_rd and wb_data show the held rd and value.
  - At the edge, rf[rd]←value.
  - flags_q←held flags for ops 0–14; LDI leaves flags_q unchanged.
  - Go to IDLE.
- Unused ops 6–14 are forwarded unchanged. The ALU returns 0 for them, so rd is written 0 and flags_q becomes {0,1,0,0}.
- NOT uses alu_a only; alu_b is still loaded from rs2 and ignored.
- rs1, rs2 and rd may alias. The sources are read at the accept edge, before any write from the same instruction.
- instr_valid while not ready is ignored. Inputs need not be held stable after acceptance.
- Register file has no external read port; verification observes it via wb_* and via subsequent ops.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - state=IDLE, rf all 0x0000;
  - alu_a=alu_b=0, alu_sel=0;
  - flags_q=0, wb_valid=0, wb_rd=0, wb_data=0;
  - instr_ready=1 once rst_n=1.
- Accept at edge N gives EXEC in cycle N+1 and WB in cycle N+2. rf and flags_q are updated at the end of N+2.
- instr_ready is high again in cycle N+3. Throughput is one instruction per 3 cycles.
- An instruction accepted at N+3 reading the previous rd sees the written value; no forwarding is needed.
- alu_a, alu_b and alu_sel hold their last values outside accept edges.
- wb_rd and wb_data hold after WB; only wb_valid drops.
- Reset mid-EXEC or mid-WB:
  - the instruction is dropped with no rf or flags write;
  - wb_valid falls immediately (asynchronously);
  - all state returns to reset values.
- Arithmetic: widths follow the ALU, with no extension or masking in this block. carry on SUB is bit 16 of the 17-bit difference, i.e. 1 on borrow.

## Test plan
- Reset then LDI r1=0x7FFF, LDI r2=0x0001, ADD r3=r1+r2:
  - wb_data=0x8000, wb_rd=3 two cycles after accept;
  - flags_q={0,0,1,1}.
- SUB r4=r2−r2 → wb_data=0x0000, flags_q={0,1,0,0}.
- SUB r5=r0−r2 (0−1) → 0xFFFF, flags_q={1,0,1,0}.
- LDI after ADD → flags_q unchanged.
- Hold instr_valid high for 9 cycles with fixed op → exactly 3 accepts, instr_ready pattern 1,0,0 repeating, and 3 wb_valid pulses.
- Aliasing: with r1=0x00F0, XOR r1=r1^r1 → 0x0000, zero flag set.
- Op 9 (unused) on r1,r2 → rd written 0x0000, flags_q={0,1,0,0}.
- Assert rst_n=0 during EXEC of ADD r6:
  - no wb_valid pulse;
  - a later ADD r7=r6+r0 returns 0x0000 after a fresh LDI-free run.
- The last case also shows rf cleared to zero.
